tick_timer_sched: RTL and testbench

Multi-channel microsecond timer scheduler built on the shared clk_1Mhz divider output. It gates the divider through `div_run` and turns each rising edge of `tick_in` into a one-Clk tick pulse. That pulse is shared by NCH independent down-counting channels, each configurable as one-shot or periodic. Software sees a small register slave; expirations are latched as sticky status bits and combined into one maskable `irq`.

---
 rtl/tick_timer_sched.sv | 192 +++++++++++++++++++
 tb/tb_tick_timer_sched.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tick_timer_sched.sv
// tick_timer_sched: multi-channel microsecond timer scheduler.
// Turns rising edges of the divider output into one-Clk ticks, feeds NCH
// down-counting channels (one-shot or periodic), and exposes a small
// register slave with sticky expiry status and a maskable irq.
// Optional build macro: TICK_SCHED_SYNC_EN adds a 2-flop synchronizer on tick_in.
module tick_timer_sched #(
   parameter int unsigned NCH = 4,
   parameter int unsigned CW  = 16
) (
   input  logic           Clk,
   input  logic           ResetN,
   input  logic [3:0]     address,
   input  logic           write,
   input  logic [31:0]    writedata,
   input  logic           read,
   output logic [31:0]    readdata,
   input  logic           tick_in,
   output logic           div_run,
   output logic [NCH-1:0] expired,
   output logic           irq
);

   typedef enum logic [1:0] {StIdle, StArmed, StDone} ch_state_e;

   localparam logic [3:0] AddrCtrl   = 4'd0;
   localparam logic [3:0] AddrStatus = 4'd1;
   localparam logic [3:0] AddrMask   = 4'd2;

   logic            en_q, en_d;
   logic [NCH-1:0]  status_q, status_d, status_set;
   logic [NCH-1:0]  mask_q, mask_d;
   logic [31:0]     rdata_q, rdata_d;

   ch_state_e       state_q    [NCH];
   ch_state_e       state_d    [NCH];
   logic [CW-1:0]   cnt_q      [NCH];
   logic [CW-1:0]   cnt_d      [NCH];
   logic [CW-1:0]   reload_q   [NCH];
   logic [CW-1:0]   reload_d   [NCH];
   logic            periodic_q [NCH];
   logic            periodic_d [NCH];

   logic            tick_r_q, tick_prev_q, tick_p;

   // Upper write-data bits have no register behind them.
   logic unused_wdata;
   assign unused_wdata = ^writedata[31:18];

`ifdef TICK_SCHED_SYNC_EN
   logic sync1_q, sync2_q;

   // Resynchronize tick_in, then one more stage so the edge detector sees clean levels.
   always_ff @(posedge Clk or negedge ResetN) begin
      if (!ResetN) begin
         sync1_q     <= 1'b0;
         sync2_q     <= 1'b0;
         tick_r_q    <= 1'b0;
         tick_prev_q <= 1'b0;
      end else begin
         sync1_q     <= tick_in;
         sync2_q     <= sync1_q;
         tick_r_q    <= sync2_q;
         tick_prev_q <= tick_r_q;
      end
   end
`else
   // tick_in is already Clk-synchronous; register it once for edge detection.
   always_ff @(posedge Clk or negedge ResetN) begin
      if (!ResetN) begin
         tick_r_q    <= 1'b0;
         tick_prev_q <= 1'b0;
      end else begin
         tick_r_q    <= tick_in;
         tick_prev_q <= tick_r_q;
      end
   end
`endif

   // EN is sampled from the register, so a tick coinciding with an EN clear still lands.
   assign tick_p = tick_r_q & ~tick_prev_q & en_q;

   // Per-channel next state: a CFG write overrides any tick on the same cycle.
   always_comb begin
      status_set = '0;
      for (int c = 0; c < NCH; c++) begin
         state_d[c]    = state_q[c];
         cnt_d[c]      = cnt_q[c];
         reload_d[c]   = reload_q[c];
         periodic_d[c] = periodic_q[c];
         if (write && (address == 4'(4 + c))) begin
            reload_d[c]   = writedata[CW-1:0];
            periodic_d[c] = writedata[17];
            if (writedata[16] && (writedata[CW-1:0] != '0)) begin
               cnt_d[c]   = writedata[CW-1:0];
               state_d[c] = StArmed;
            end else begin
               cnt_d[c]   = '0;
               state_d[c] = StIdle;
            end
         end else if (tick_p && (state_q[c] == StArmed)) begin
            if (cnt_q[c] == CW'(1)) begin
               status_set[c] = 1'b1;
               if (periodic_q[c]) begin
                  cnt_d[c] = reload_q[c];
               end else begin
                  cnt_d[c]   = '0;
                  state_d[c] = StDone;
               end
            end else begin
               cnt_d[c] = cnt_q[c] - CW'(1);
            end
         end
      end
   end

   // Global registers; a new expiry beats a same-cycle write-1-to-clear.
   always_comb begin
      en_d     = en_q;
      mask_d   = mask_q;
      status_d = status_q;
      if (write && (address == AddrCtrl)) begin
         en_d = writedata[0];
      end
      if (write && (address == AddrMask)) begin
         mask_d = writedata[NCH-1:0];
      end
      if (write && (address == AddrStatus)) begin
         status_d = status_q & ~writedata[NCH-1:0];
      end
      status_d = status_d | status_set;
   end

   // Read mux; readdata is captured only on a read strobe and held otherwise.
   always_comb begin
      rdata_d = rdata_q;
      if (read) begin
         rdata_d = '0;
         if (address == AddrCtrl) begin
            rdata_d[0] = en_q;
         end
         if (address == AddrStatus) begin
            rdata_d[NCH-1:0] = status_q;
         end
         if (address == AddrMask) begin
            rdata_d[NCH-1:0] = mask_q;
         end
         for (int c = 0; c < NCH; c++) begin
            if (address == 4'(4 + c)) begin
               rdata_d[CW-1:0] = reload_q[c];
               rdata_d[16]     = (state_q[c] == StArmed);
               rdata_d[17]     = periodic_q[c];
            end
            if (address == 4'(8 + c)) begin
               rdata_d[CW-1:0] = cnt_q[c];
            end
         end
      end
   end

   // State registers for the register file and all channel FSMs.
   always_ff @(posedge Clk or negedge ResetN) begin
      if (!ResetN) begin
         en_q     <= 1'b0;
         status_q <= '0;
         mask_q   <= '0;
         rdata_q  <= '0;
         for (int c = 0; c < NCH; c++) begin
            state_q[c]    <= StIdle;
            cnt_q[c]      <= '0;
            reload_q[c]   <= '0;
            periodic_q[c] <= 1'b0;
         end
      end else begin
         en_q     <= en_d;
         status_q <= status_d;
         mask_q   <= mask_d;
         rdata_q  <= rdata_d;
         for (int c = 0; c < NCH; c++) begin
            state_q[c]    <= state_d[c];
            cnt_q[c]      <= cnt_d[c];
            reload_q[c]   <= reload_d[c];
            periodic_q[c] <= periodic_d[c];
         end
      end
   end

   assign readdata = rdata_q;
   assign div_run  = en_q;
   assign expired  = status_q;
   assign irq      = |(status_q & mask_q);

endmodule

// File: tb/tb_tick_timer_sched.sv
// Self-checking bench for tick_timer_sched: register table plus tick sequences.
module tb_tick_timer_sched;

   localparam int unsigned NCH = 4;
   localparam int unsigned CW  = 16;
`ifdef TICK_SCHED_SYNC_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 1;
`endif

   localparam logic [3:0] ACTRL = 4'd0;
   localparam logic [3:0] ASTAT = 4'd1;
   localparam logic [3:0] AMASK = 4'd2;

   logic           Clk       = 1'b0;
   logic           ResetN    = 1'b0;
   logic [3:0]     address   = 4'd0;
   logic           write     = 1'b0;
   logic [31:0]    writedata = 32'd0;
   logic           read      = 1'b0;
   logic [31:0]    readdata;
   logic           tick_in;
   logic           div_run;
   logic [NCH-1:0] expired;
   logic           irq;

   logic use_div  = 1'b0;
   logic man_tick = 1'b0;
   logic div_clk  = 1'b0;
   int   div_cnt  = 0;
   int   div_rises = 0;

   int n_total = 0;
   int n_pass  = 0;

   typedef struct {
      logic [31:0] exp;
      string       name;
   } sb_t;
   sb_t sb_q[$];

   typedef struct {
      bit          wr;
      logic [3:0]  addr;
      logic [31:0] wdata;
      logic [31:0] exp;
   } vec_t;
   vec_t vecs [28];

   tick_timer_sched #(.NCH(NCH), .CW(CW)) dut (
      .Clk       (Clk),
      .ResetN    (ResetN),
      .address   (address),
      .write     (write),
      .writedata (writedata),
      .read      (read),
      .readdata  (readdata),
      .tick_in   (tick_in),
      .div_run   (div_run),
      .expired   (expired),
      .irq       (irq)
   );

   always #5 Clk = ~Clk;

   assign tick_in = use_div ? div_clk : man_tick;

   // Divider model: held low while stopped, 25-cycle half period while running.
   always @(posedge Clk or negedge ResetN) begin
      if (!ResetN) begin
         div_cnt <= 0;
         div_clk <= 1'b0;
      end else if (!div_run) begin
         div_cnt <= 0;
         div_clk <= 1'b0;
      end else if (div_cnt == 24) begin
         div_cnt <= 0;
         div_clk <= ~div_clk;
         if (!div_clk) div_rises <= div_rises + 1;
      end else begin
         div_cnt <= div_cnt + 1;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
   endtask

   task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
      address   = a;
      writedata = d;
      write     = 1'b1;
      @(negedge Clk);
      write     = 1'b0;
   endtask

   task automatic bus_read(input logic [3:0] a, input logic [31:0] exp, input string name);
      sb_t e;
      e.exp  = exp;
      e.name = name;
      sb_q.push_back(e);
      address = a;
      read    = 1'b1;
      @(negedge Clk);
      read    = 1'b0;
      e = sb_q.pop_front();
      chk(e.name, readdata, e.exp);
   endtask

   task automatic tick();
      man_tick = 1'b1;
      repeat (3) @(negedge Clk);
      man_tick = 1'b0;
      repeat (4) @(negedge Clk);
   endtask

   // Raise tick_in and issue a write sampled on the very edge the tick updates counts.
   task automatic tick_with_write(input logic [3:0] a, input logic [31:0] d);
      man_tick = 1'b1;
      repeat (LAT) @(negedge Clk);
      bus_write(a, d);
      man_tick = 1'b0;
      repeat (4) @(negedge Clk);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
      $fatal(1);
   end

   initial begin
      bit found;
      int base;

      for (int a = 0; a < 16; a++) vecs[a] = '{1'b0, 4'(a), 32'h0, 32'h0};
      vecs[16] = '{1'b1, AMASK, 32'hFFFF_FFFF, 32'h0000_000F};
      vecs[17] = '{1'b1, AMASK, 32'h0000_0000, 32'h0000_0000};
      vecs[18] = '{1'b1, ACTRL, 32'hFFFF_FFFF, 32'h0000_0001};
      vecs[19] = '{1'b1, ACTRL, 32'hFFFF_FFFE, 32'h0000_0000};
      vecs[20] = '{1'b1, 4'd7,  32'h0003_1234, 32'h0003_1234};
      vecs[21] = '{1'b0, 4'd11, 32'h0,         32'h0000_1234};
      vecs[22] = '{1'b1, 4'd7,  32'h0003_0000, 32'h0002_0000};
      vecs[23] = '{1'b0, 4'd11, 32'h0,         32'h0000_0000};
      vecs[24] = '{1'b1, 4'd7,  32'h0000_0000, 32'h0000_0000};
      vecs[25] = '{1'b1, 4'd3,  32'hFFFF_FFFF, 32'h0000_0000};
      vecs[26] = '{1'b1, 4'd15, 32'hFFFF_FFFF, 32'h0000_0000};
      vecs[27] = '{1'b1, ASTAT, 32'h0000_000F, 32'h0000_0000};

      // Reset
      repeat (3) @(negedge Clk);
      chk("rst_div_run", 32'(div_run), 32'h0);
      chk("rst_irq", 32'(irq), 32'h0);
      chk("rst_expired", 32'(expired), 32'h0);
      ResetN = 1'b1;
      @(negedge Clk);

      // Register table: reset reads of every address, then write/readback
      for (int i = 0; i < 28; i++) begin
         if (vecs[i].wr) bus_write(vecs[i].addr, vecs[i].wdata);
         bus_read(vecs[i].addr, vecs[i].exp, $sformatf("vec%0d_addr%0d", i, vecs[i].addr));
      end

      // One-shot channel 0 driven by the divider model
      bus_write(ACTRL, 32'h1);
      chk("div_run_on", 32'(div_run), 32'h1);
      use_div = 1'b1;
      base = div_rises;
      bus_write(4'd4, 32'h0001_0003);
      found = 1'b0;
      for (int i = 0; i < 400 && !found; i++) begin
         @(negedge Clk);
         if (expired[0]) found = 1'b1;
      end
      chk("ch0_expired_in_budget", 32'(found), 32'h1);
      chk("ch0_expiry_tick_count", 32'(div_rises - base), 32'd3);
      use_div = 1'b0;
      @(negedge Clk);
      bus_read(4'd4, 32'h0000_0003, "cfg0_enable_after_done");
      bus_read(4'd8, 32'h0, "cnt0_after_done");
      chk("irq_masked_off", 32'(irq), 32'h0);
      bus_write(AMASK, 32'h1);
      chk("irq_mask_on", 32'(irq), 32'h1);
      bus_write(ASTAT, 32'h1);
      chk("irq_after_clear", 32'(irq), 32'h0);
      chk("expired_after_clear", 32'(expired), 32'h0);

      // Periodic channel 1, reload 2
      bus_write(4'd5, 32'h0003_0002);
      tick();
      chk("ch1_not_yet", 32'(expired[1]), 32'h0);
      bus_read(4'd9, 32'd1, "cnt1_after_1");
      tick();
      chk("ch1_expired", 32'(expired[1]), 32'h1);
      chk("irq_bit1_masked", 32'(irq), 32'h0);
      bus_read(4'd9, 32'd2, "cnt1_reloaded");
      bus_write(ASTAT, 32'h2);
      chk("ch1_cleared", 32'(expired[1]), 32'h0);
      tick();
      bus_read(4'd9, 32'd1, "cnt1_periodic_1");
      tick_with_write(ASTAT, 32'h2);
      chk("ch1_set_beats_clear", 32'(expired[1]), 32'h1);
      bus_read(4'd9, 32'd2, "cnt1_reloaded_again");
      bus_write(4'd5, 32'h0);
      bus_write(ASTAT, 32'h2);
      chk("ch1_cleared_again", 32'(expired), 32'h0);

      // Channel 2 freeze while CTRL.EN=0; EN clear on a tick cycle still applies the tick
      bus_write(4'd6, 32'h0001_0005);
      tick();
      bus_read(4'd10, 32'd4, "cnt2_after_1");
      tick_with_write(ACTRL, 32'h0);
      bus_read(4'd10, 32'd3, "cnt2_en_clear_tick_applied");
      chk("div_run_off", 32'(div_run), 32'h0);
      for (int k = 0; k < 10; k++) begin
         tick();
         bus_read(4'd10, 32'd3, $sformatf("cnt2_frozen_%0d", k));
         repeat (43) @(negedge Clk);
      end
      bus_write(ACTRL, 32'h1);
      tick();
      tick();
      chk("ch2_not_yet", 32'(expired[2]), 32'h0);
      bus_read(4'd10, 32'd1, "cnt2_resumed");
      tick();
      chk("ch2_expired", 32'(expired[2]), 32'h1);
      bus_read(4'd10, 32'd0, "cnt2_done");
      bus_read(4'd6, 32'h0000_0005, "cfg2_done_readback");

      // Channel 0: CFG write beats a same-cycle tick; RELOAD=0 stays idle
      bus_write(4'd4, 32'h0001_0006);
      tick_with_write(4'd4, 32'h0001_0004);
      bus_read(4'd8, 32'd4, "cnt0_write_beats_tick");
      tick();
      bus_read(4'd8, 32'd3, "cnt0_after_rewrite_tick");
      bus_write(4'd4, 32'h0001_0000);
      bus_read(4'd4, 32'h0, "cfg0_reload0_idle");
      tick();
      tick();
      bus_read(4'd8, 32'd0, "cnt0_reload0_count");
      chk("ch0_reload0_no_expiry", 32'(expired[0]), 32'h0);

      // Asynchronous reset mid-count
      bus_write(4'd7, 32'h0001_000A);
      bus_write(AMASK, 32'hF);
      tick();
      bus_read(4'd11, 32'd9, "cnt3_before_reset");
      chk("irq_before_reset", 32'(irq), 32'h1);
      ResetN = 1'b0;
      #1;
      chk("async_rst_div_run", 32'(div_run), 32'h0);
      chk("async_rst_irq", 32'(irq), 32'h0);
      chk("async_rst_expired", 32'(expired), 32'h0);
      @(negedge Clk);
      ResetN = 1'b1;
      @(negedge Clk);
      bus_read(4'd11, 32'd0, "cnt3_after_reset");
      bus_read(4'd7, 32'd0, "cfg3_after_reset");
      bus_read(ACTRL, 32'd0, "ctrl_after_reset");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
